mul_arbiter: RTL and testbench

- Shares the single combinational 16-bit multiplier (`rs1_reg`/`rs2_reg` in; `mul_rd` and `m_co` out) between NREQ requesters, e.g. the execute stage and a microcode/address unit.
- Grants round-robin and registers the operands driven to the multiplier.
- Waits a fixed number of cycles for the multiplier to settle, then captures the result and overflow flag.
- Returns the result to the owning requester over a valid/ready response channel.

---
 rtl/mul_arb_pkg.sv | 23 ++
 rtl/mul_rr_arbiter.sv | 30 +++
 rtl/mul_arbiter.sv | 130 +++++++++++++
 tb/tb_mul_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// The optional zero-operand bypass is enabled with MUL_ZERO_BYPASS_EN.
package mul_arb_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, RESP} arb_state_t;

   localparam int unsigned MUL_W = 16;

   // One-hot round-robin pick over up to 4 requesters; the search starts at ptr+1.
   function automatic logic [3:0] rr_pick(input logic [3:0]  req,
                                          input logic [1:0]  ptr,
                                          input int unsigned n);
      logic [3:0] g;
      logic [1:0] idx;
      g = '0;
      for (int unsigned k = 1; k <= n; k++) begin
         idx = 2'((32'(ptr) + k) % n);
         if (g == '0 && req[idx]) g[idx] = 1'b1;
      end
      return g;
   endfunction

endpackage

// File: rtl/mul_rr_arbiter.sv
// Combinational round-robin selection between the multiplier requesters.
// Produces both the one-hot grant and its encoded index.
module mul_rr_arbiter
   import mul_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned PW   = 1
) (
   input  logic [NREQ-1:0] req_valid_i,
   input  logic [PW-1:0]   rr_ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [PW-1:0]   grant_idx_o,
   output logic            any_o
);

   logic [3:0] req4;
   logic [3:0] g4;
   logic [1:0] gi;

   always_comb begin
      req4              = '0;
      req4[NREQ-1:0]    = req_valid_i;
      g4                = rr_pick(req4, 2'(rr_ptr_i), NREQ);
      grant_o           = g4[NREQ-1:0];
      gi                = g4[3] ? 2'd3 : g4[2] ? 2'd2 : g4[1] ? 2'd1 : 2'd0;
      grant_idx_o       = PW'(gi);
      any_o             = |g4;
   end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one combinational W-bit multiplier between NREQ requesters.
// Define MUL_ZERO_BYPASS_EN to return zero products after a single edge.
module mul_arbiter
   import mul_arb_pkg::*;
#(
   parameter int unsigned NREQ          = 2,
   parameter int unsigned W             = MUL_W,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*W-1:0]   req_rs1,
   input  logic [NREQ*W-1:0]   req_rs2,
   output logic [NREQ-1:0]     rsp_valid,
   input  logic [NREQ-1:0]     rsp_ready,
   output logic [W-1:0]        rsp_rd,
   output logic                rsp_ovf,
   output logic [W-1:0]        mul_rs1,
   output logic [W-1:0]        mul_rs2,
   input  logic [W-1:0]        mul_rd,
   input  logic [W-1:0]        mul_co
);

   localparam int unsigned PW = (NREQ > 2) ? 2 : 1;
   localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

   arb_state_t      state_q;
   logic [PW-1:0]   rr_ptr_q;
   logic [PW-1:0]   owner_q;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    rs1_q, rs2_q, rd_q;
   logic            ovf_q;
   logic [NREQ-1:0] rsp_valid_q;
`ifdef MUL_ZERO_BYPASS_EN
   logic            zero_q;
`endif

   logic [NREQ-1:0] grant;
   logic [PW-1:0]   grant_idx;
   logic            grant_any;
   logic [W-1:0]    sel_rs1, sel_rs2;

   mul_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
      .req_valid_i (req_valid),
      .rr_ptr_i    (rr_ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .any_o       (grant_any)
   );

   always_comb begin
      sel_rs1 = '0;
      sel_rs2 = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_idx == PW'(i)) begin
            sel_rs1 = req_rs1[i*W +: W];
            sel_rs2 = req_rs2[i*W +: W];
         end
      end
   end

   // Reset sits in IDLE, so the accept strobe is also gated by rst_n.
   assign req_ready = (rst_n && state_q == IDLE) ? grant : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rd    = rd_q;
   assign rsp_ovf   = ovf_q;
   assign mul_rs1   = rs1_q;
   assign mul_rs2   = rs2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= PW'(NREQ - 1);
         owner_q     <= '0;
         cnt_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         ovf_q       <= 1'b0;
         rsp_valid_q <= '0;
`ifdef MUL_ZERO_BYPASS_EN
         zero_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_any) begin
                  rs1_q    <= sel_rs1;
                  rs2_q    <= sel_rs2;
                  owner_q  <= grant_idx;
                  rr_ptr_q <= grant_idx;
                  state_q  <= SETTLE;
`ifdef MUL_ZERO_BYPASS_EN
                  // A zero operand shortens the wait to one edge and forces a zero result.
                  zero_q   <= (sel_rs1 == '0) || (sel_rs2 == '0);
                  cnt_q    <= ((sel_rs1 == '0) || (sel_rs2 == '0)) ? CW'(1) : CW'(SETTLE_CYCLES);
`else
                  cnt_q    <= CW'(SETTLE_CYCLES);
`endif
               end
            end
            SETTLE: begin
               if (cnt_q == CW'(1)) begin
`ifdef MUL_ZERO_BYPASS_EN
                  rd_q  <= (zero_q || mul_co != '0) ? '0 : mul_rd;
                  ovf_q <= !zero_q && (mul_co != '0);
`else
                  rd_q  <= (mul_co == '0) ? mul_rd : '0;
                  ovf_q <= (mul_co != '0);
`endif
                  rsp_valid_q <= NREQ'(1) << owner_q;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready[owner_q]) begin
                  rsp_valid_q <= '0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model; honours MUL_ZERO_BYPASS_EN when defined.
module tb_mul_arbiter;

   localparam int unsigned NREQ = 2;
   localparam int unsigned W    = 16;
   localparam int unsigned SC   = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NREQ*W-1:0]   req_rs1, req_rs2;
   logic [W-1:0]        rsp_rd, mul_rs1, mul_rs2, mul_rd, mul_co;
   logic                rsp_ovf;

   int n_assert = 0;
   int n_fail   = 0;
   int last_grant;

   always #5 clk = ~clk;

   // External multiplier: low half is the product, high half is the carry-out.
   assign {mul_co, mul_rd} = 32'(mul_rs1) * 32'(mul_rs2);

   mul_arbiter #(.NREQ(NREQ), .W(W), .SETTLE_CYCLES(SC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rs1   (req_rs1),
      .req_rs2   (req_rs2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rd    (rsp_rd),
      .rsp_ovf   (rsp_ovf),
      .mul_rs1   (mul_rs1),
      .mul_rs2   (mul_rs2),
      .mul_rd    (mul_rd),
      .mul_co    (mul_co)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_grant(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      return 0;
   endfunction

   // {ovf, rd} from the arithmetic product.
   function automatic logic [W:0] exp_result(input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      p = longint'(a) * longint'(b);
      if (p >= (longint'(1) << W)) return {1'b1, W'(0)};
      return {1'b0, W'(p)};
   endfunction

   function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_ZERO_BYPASS_EN
      if (a == '0 || b == '0) return 1;
`endif
      return SC;
   endfunction

   function automatic logic [W-1:0] rand_op();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return W'($urandom_range(1, 255));
         2:       return W'($urandom);
         default: return W'($urandom_range(256, 1023));
      endcase
   endfunction

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      #1;
      check("rst rsp_valid", 32'(rsp_valid), 0);
      check("rst req_ready", 32'(req_ready), 0);
      check("rst ops",       {mul_rs1, mul_rs2}, 0);
      check("rst rd/ovf",    {15'd0, rsp_ovf, rsp_rd}, 0);
      repeat (2) @(negedge clk);
      rst_n      = 1'b1;
      last_grant = NREQ - 1;
   endtask

   // Called at a negedge with req_valid already set; runs one full transaction.
   task automatic txn(input int bp, input bit keep, input string tag);
      int              g, lat, waited;
      logic [W-1:0]    a, b;
      logic [W:0]      r;
      logic [NREQ-1:0] oh;
      waited = 0;
      #1;
      while (req_ready === '0 && waited < 20) begin
         @(negedge clk); #1;
         waited++;
      end
      g  = exp_grant(req_valid, last_grant);
      oh = NREQ'(1) << g;
      check({tag, " grant"}, 32'(req_ready), 32'(oh));
      a   = req_rs1[g*W +: W];
      b   = req_rs2[g*W +: W];
      r   = exp_result(a, b);
      lat = exp_latency(a, b);
      last_grant = g;
      @(posedge clk); #1;
      if (!keep) req_valid[g] = 1'b0;
      for (int e = 0; e < lat; e++) begin
         @(negedge clk);
         check({tag, " settle rsp_valid"}, 32'(rsp_valid), 0);
         check({tag, " settle ops"}, {mul_rs1, mul_rs2}, {a, b});
         check({tag, " settle req_ready"}, 32'(req_ready), 0);
      end
      @(negedge clk);
      check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(oh));
      check({tag, " rsp_rd"}, 32'(rsp_rd), 32'(r[W-1:0]));
      check({tag, " rsp_ovf"}, 32'(rsp_ovf), 32'(r[W]));
      rsp_ready = ~oh;
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         check({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'(oh));
         check({tag, " hold rd/ovf"}, {15'd0, rsp_ovf, rsp_rd}, {15'd0, r});
         check({tag, " hold req_ready"}, 32'(req_ready), 0);
      end
      rsp_ready = oh;
      @(posedge clk); #1;
      rsp_ready = '0;
      @(negedge clk);
      check({tag, " rsp_valid clear"}, 32'(rsp_valid), 0);
   endtask

   initial begin
      rst_n     = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      req_rs1   = '0;
      req_rs2   = '0;
      @(negedge clk);
      do_reset();
      @(negedge clk);
      check("post-rst rsp_valid", 32'(rsp_valid), 0);
      check("post-rst req_ready", 32'(req_ready), 0);

      // Single requester 7 x 6.
      req_rs1[0 +: W] = 16'd7;
      req_rs2[0 +: W] = 16'd6;
      req_valid = 2'b01;
      txn(0, 1'b0, "single");

      // Both requesters continuously valid: grants alternate starting at 0.
      do_reset();
      req_rs1 = {16'd4, 16'd3};
      req_rs2 = {16'd4, 16'd5};
      req_valid = 2'b11;
      for (int t = 0; t < 4; t++) begin
         check("alt expected owner", 32'(exp_grant(req_valid, last_grant)), 32'(t % 2));
         txn(0, 1'b1, "alternate");
      end
      req_valid = '0;

      // Overflow 300 x 300.
      req_rs1[W +: W] = 16'd300;
      req_rs2[W +: W] = 16'd300;
      req_valid = 2'b10;
      txn(1, 1'b0, "overflow");

      // Backpressure on requester 0 while requester 1 waits.
      do_reset();
      req_rs1 = {16'd11, 16'd9};
      req_rs2 = {16'd13, 16'd8};
      req_valid = 2'b11;
      txn(5, 1'b0, "backpressure0");
      check("bp req1 granted next", 32'(req_ready), 32'(2'b10));
      txn(0, 1'b0, "backpressure1");

      // Reset during SETTLE abandons the transaction.
      do_reset();
      req_rs1[0 +: W] = 16'd5;
      req_rs2[0 +: W] = 16'd5;
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("midrst ops loaded", {mul_rs1, mul_rs2}, {16'd5, 16'd5});
      rst_n = 1'b0;
      req_valid = 2'b10;
      #1;
      check("midrst ops", {mul_rs1, mul_rs2}, 0);
      check("midrst rd/ovf", {15'd0, rsp_ovf, rsp_rd}, 0);
      check("midrst rsp_valid", 32'(rsp_valid), 0);
      check("midrst req_ready", 32'(req_ready), 0);
      @(negedge clk);
      req_valid  = '0;
      rst_n      = 1'b1;
      last_grant = NREQ - 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("midrst no rsp", 32'(rsp_valid), 0);
      end
      req_rs1[0 +: W] = 16'd2;
      req_rs2[0 +: W] = 16'd3;
      req_valid = 2'b01;
      txn(0, 1'b0, "after-rst");

      // Zero operand 0 x 9.
      req_rs1[0 +: W] = 16'd0;
      req_rs2[0 +: W] = 16'd9;
      req_valid = 2'b01;
      txn(0, 1'b0, "zero");

      // Randomized traffic.
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < NREQ; i++) begin
            req_rs1[i*W +: W] = rand_op();
            req_rs2[i*W +: W] = rand_op();
         end
         req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         txn($urandom_range(0, 3), 1'b0, "rand");
      end
      req_valid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
